// File: rtl/shift_seq.sv
// Command sequencer for a 4-bit external shift register: parallel load,
// a counted run of shift/rotate cycles, then capture of the returned word.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; command fields latched on acceptance
// LOAD    | one parallel-load cycle of the latched din
// SHIFT   | latched op issued once per cycle until the down-counter ends
// CAPTURE | shift register idle; sr_out registered into result
// DONE    | one-cycle completion pulse, then back to IDLE
module shift_seq #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] count,
  input  logic [3:0]       din,
  input  logic [3:0]       sr_out,
  output logic             sr_enable,
  output logic [1:0]       sr_select,
  output logic [3:0]       sr_data,
  output logic             busy,
  output logic             done,
  output logic [3:0]       result
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SHIFT   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       din_q;
  logic [CNT_W-1:0] cnt_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        if ((cnt_q != '0) && (op_q != 2'b00)) state_nx = S_SHIFT;
        else                                  state_nx = S_CAPTURE;
      end
      S_SHIFT: begin
        // cnt_rem still holds this cycle's remaining shifts; 1 means last one
        if (cnt_rem == CNT_W'(1)) state_nx = S_CAPTURE;
      end
      S_CAPTURE: state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Command latch: only written on acceptance, so input changes mid-command are harmless
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q  <= 2'b00;
      cnt_q <= '0;
      din_q <= 4'b0000;
    end else if ((state == S_IDLE) && start) begin
      op_q  <= op;
      cnt_q <= count;
      din_q <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_rem <= '0;
    end else if (state == S_LOAD) begin
      cnt_rem <= cnt_q;
    end else if (state == S_SHIFT) begin
      cnt_rem <= cnt_rem - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result <= 4'b0000;
    end else if (state == S_CAPTURE) begin
      result <= sr_out;
    end
  end

  always_comb begin
    sr_enable = (state == S_LOAD) || (state == S_SHIFT);
    sr_select = (state == S_SHIFT) ? op_q : 2'b00;
    sr_data   = din_q;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
  end

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq driving a behavioural 4-bit shift register.
module tb_shift_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [2:0] count;
  logic [3:0] din;
  logic [3:0] sr_out;
  logic       sr_enable;
  logic [1:0] sr_select;
  logic [3:0] sr_data;
  logic       busy;
  logic       done;
  logic [3:0] result;

  int total = 0;
  int bad   = 0;

  logic [3:0] sr_q = 4'b0000;

  shift_seq #(.CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .count     (count),
    .din       (din),
    .sr_out    (sr_out),
    .sr_enable (sr_enable),
    .sr_select (sr_select),
    .sr_data   (sr_data),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift register model: 00 load, 01 shr zero fill, 10 shl zero fill, 11 rotate right
  always @(posedge clk) begin
    if (sr_enable) begin
      case (sr_select)
        2'b00: sr_q <= sr_data;
        2'b01: sr_q <= {1'b0, sr_q[3:1]};
        2'b10: sr_q <= {sr_q[2:0], 1'b0};
        2'b11: sr_q <= {sr_q[0], sr_q[3:1]};
        default: sr_q <= sr_q;
      endcase
    end
  end
  assign sr_out = sr_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one command and observe cycles 1..exp_done+1 at the falling edge.
  task automatic run_cmd(input string name, input logic [1:0] o, input logic [2:0] c,
                         input logic [3:0] d, input logic [3:0] exp_res,
                         input int exp_done, input int exp_shifts, input bit poke);
    int done_cyc = -1;
    int ndone    = 0;
    int shifts   = 0;
    int loads    = 0;
    int busy_bad = 0;
    int sel_bad  = 0;
    logic [3:0] data_c1 = 4'b0000;
    @(negedge clk);
    start = 1'b1; op = o; count = c; din = d;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~o; count = ~c; din = ~d;
    for (int cyc = 1; cyc <= exp_done + 1; cyc++) begin
      @(negedge clk);
      if (cyc == 1) data_c1 = sr_data;
      if ((cyc <= exp_done) && (busy !== 1'b1)) busy_bad++;
      if ((cyc == exp_done + 1) && (busy !== 1'b0)) busy_bad++;
      if (sr_enable === 1'b1 && sr_select === 2'b00) loads++;
      if (sr_enable === 1'b1 && sr_select !== 2'b00) begin
        shifts++;
        if (sr_select !== o) sel_bad++;
      end
      if (done === 1'b1) begin
        ndone++;
        done_cyc = cyc;
      end
      if (poke && cyc == 2) begin
        start = 1'b1; din = 4'hF; op = 2'b00; count = 3'd0;
      end
      if (poke && cyc == 3) start = 1'b0;
    end
    chk({name, ".data"},   32'(data_c1), 32'(d));
    chk({name, ".loads"},  32'(loads), 32'd1);
    chk({name, ".shifts"}, 32'(shifts), 32'(exp_shifts));
    chk({name, ".sel"},    32'(sel_bad), 32'd0);
    chk({name, ".donecyc"}, 32'(done_cyc), 32'(exp_done));
    chk({name, ".ndone"},  32'(ndone), 32'd1);
    chk({name, ".busy"},   32'(busy_bad), 32'd0);
    chk({name, ".result"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    int nd;
    rst = 1'b0; start = 1'b0; op = 2'b00; count = 3'd0; din = 4'h0;
    #1;
    chk("rst.busy",   32'(busy), 32'd0);
    chk("rst.done",   32'(done), 32'd0);
    chk("rst.en",     32'(sr_enable), 32'd0);
    chk("rst.sel",    32'(sr_select), 32'd0);
    chk("rst.data",   32'(sr_data), 32'd0);
    chk("rst.result", 32'(result), 32'd0);
    #20;
    @(negedge clk);
    rst = 1'b1;

    run_cmd("shr1",  2'b01, 3'd1, 4'b1010, 4'b0101, 4, 1, 1'b0);
    run_cmd("shl2",  2'b10, 3'd2, 4'b1010, 4'b1000, 5, 2, 1'b0);
    run_cmd("rot3",  2'b11, 3'd3, 4'b1010, 4'b0101, 6, 3, 1'b0);
    run_cmd("rot7",  2'b11, 3'd7, 4'b1010, 4'b0101, 10, 7, 1'b0);
    run_cmd("load",  2'b00, 3'd5, 4'b0110, 4'b0110, 3, 0, 1'b0);
    run_cmd("poke",  2'b11, 3'd3, 4'b1010, 4'b0101, 6, 3, 1'b1);
    chk("poke.idle", 32'(busy), 32'd0);

    // start held high through DONE is re-accepted right after IDLE
    @(negedge clk);
    start = 1'b1; op = 2'b00; count = 3'd5; din = 4'b0011;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if (cyc == 3) chk("hold.done1", 32'(done), 32'd1);
      if (cyc == 4) chk("hold.idle", 32'(busy), 32'd0);
      if (cyc == 5) begin
        chk("hold.relaunch", 32'(busy), 32'd1);
        start = 1'b0;
      end
      if (cyc == 7) begin
        chk("hold.done2", 32'(done), 32'd1);
        chk("hold.result", 32'(result), 32'(4'b0011));
      end
    end

    // asynchronous reset during SHIFT aborts the command
    @(negedge clk);
    start = 1'b1; op = 2'b10; count = 3'd5; din = 4'b1010;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #3;
    chk("abort.inshift", 32'(sr_select), 32'(2'b10));
    rst = 1'b0;
    #1;
    chk("abort.busy",   32'(busy), 32'd0);
    chk("abort.done",   32'(done), 32'd0);
    chk("abort.en",     32'(sr_enable), 32'd0);
    chk("abort.sel",    32'(sr_select), 32'd0);
    chk("abort.data",   32'(sr_data), 32'd0);
    chk("abort.result", 32'(result), 32'd0);
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done !== 1'b0) nd++;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0) nd++;
    end
    chk("abort.nodone", 32'(nd), 32'd0);

    run_cmd("post", 2'b10, 3'd1, 4'b0011, 4'b0110, 4, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
- REQ-001 Parameter CNT_W, default 3: width of the shift-count field; maximum shift count is 2^CNT_W-1.
- REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
- REQ-003 Port rst, input, 1: reset, asynchronous and active-low.
- REQ-004 Port start, input, 1: command request; sampled only in IDLE.
- REQ-005 Port op, input, 2: operation code.
  - 00 = load only.
  - 01 = shift right, zero fill.
  - 10 = shift left, zero fill.
  - 11 = rotate right.
- REQ-006 Port count, input, CNT_W: number of shift cycles to issue after the load.
- REQ-007 Port din, input, 4: parallel word to load into the downstream shift register.
- REQ-008 Port sr_out, input, 4: current contents returned by the shift register.
- REQ-009 Port sr_enable, output, 1: shift-register enable.
- REQ-010 Port sr_select, output, 2: shift-register mode. 00 = parallel load; other codes as defined for op.
- REQ-011 Port sr_data, output, 4: parallel load word driven to the shift register.
- REQ-012 Port busy, output, 1: high in every state except IDLE.
- REQ-013 Port done, output, 1: one-cycle completion pulse.
- REQ-014 Port result, output, 4: captured shift-register contents from the last completed command.

Function
- REQ-015 The FSM SHALL have exactly five states: IDLE, LOAD, SHIFT, CAPTURE, DONE. The state register is binary-encoded.
- REQ-016 IDLE: start=1 at a rising edge SHALL latch op, count and din into internal registers and move to LOAD. start=0 SHALL stay in IDLE.
- REQ-017 LOAD SHALL drive the load cycle:
  - outputs: sr_enable=1, sr_select=00, sr_data=latched din;
  - next state: SHIFT if latched count≠0 and latched op≠00, otherwise CAPTURE.
- REQ-018 SHIFT SHALL drive sr_enable=1 and sr_select=latched op for exactly latched count consecutive cycles, using a down-counter. It moves to CAPTURE in the cycle after the last shift cycle.
- REQ-019 CAPTURE SHALL drive sr_enable=0, register sr_out into result at the closing edge, and move to DONE.
- REQ-020 DONE SHALL assert done=1 for exactly one cycle and return to IDLE.
- REQ-021 sr_enable, sr_select and sr_data SHALL be decoded only from the registered state and latched command, with no combinational path from start, op, count or din.
- REQ-022 Outside LOAD and SHIFT the block SHALL drive sr_enable=0 and sr_select=00. sr_data SHALL hold the latched din at all times.
- REQ-023 Latency: with start sampled at edge 0 and N = latched count (or 0 when op=00), done SHALL be high in cycle N+3 and busy SHALL be high in cycles 1..N+3.
- REQ-024 start asserted while busy=1 SHALL be ignored with no side effect. A start held high through DONE SHALL be accepted at the first edge after the return to IDLE.
- REQ-025 Changes to op, count or din after acceptance SHALL NOT affect the command in progress.
- REQ-026 count = 2^CNT_W-1 SHALL issue exactly that many shift cycles, with no counter wrap.
- REQ-027 result SHALL change only at the CAPTURE edge and otherwise hold its value.

Reset
- REQ-028 rst=0 SHALL immediately, without waiting for a clock edge, force:
  - state=IDLE;
  - busy=0, done=0, sr_enable=0, sr_select=00;
  - sr_data=0000, result=0000;
  - latched op/count/din and the down-counter all cleared.
- REQ-029 Reset asserted mid-command SHALL abort the command with no done pulse. After rst returns to 1, the block SHALL accept a new start on the first rising edge.

Verification
Bench: shift_seq drives a behavioural 4-bit shift register whose codes follow REQ-005/010; sr_out feeds back to shift_seq.
- REQ-030 din=1010, op=01, count=1 -> one LOAD cycle, one SHIFT cycle with sr_select=01, result=0101, done high in cycle 4.
- REQ-031 din=1010, op=10, count=2 -> two SHIFT cycles with sr_select=10, result=1000, done high in cycle 5.
- REQ-032 din=1010, op=11, count=3 -> result=0101, done in cycle 6. Repeat with count=7: result=0101, done in cycle 10, no wrap.
- REQ-033 din=0110, op=00, count=5 -> no SHIFT cycles, result=0110, done in cycle 3.
- REQ-034 start pulsed again during SHIFT with din=1111 -> ignored, first command's result unchanged, exactly one done pulse.
- REQ-035 rst=0 asserted between clock edges during SHIFT -> all outputs take reset values before the next edge, no done pulse. After release, din=0011, op=10, count=1 -> result=0110.
